alu_op_issuer: RTL

//   Initiator side of the Alu32Bit operand/result interface. Accepts ALU requests on a valid/ready port,

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_wait_counter.sv | 38 +++
 rtl/alu_op_issuer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, issuer state encoding and default latencies.
// Also used by Alu32Bit.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MOD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

    localparam int unsigned DEF_COMB_CYCLES      = 1;
    localparam int unsigned DEF_MOD_START_CYCLES = 1;
    localparam int unsigned DEF_MOD_CYCLES       = 64;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// Down-counter for the issuer's START/WAIT phases: loads on state entry,
// decrements when enabled and saturates at zero.
module alu_wait_counter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one request at a time to Alu32Bit, waits its fixed latency, returns the result.
// Optional macro ALU_ISSUER_DIVZERO_EN: answer MOD by zero locally with rsp_err=1.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned COMB_CYCLES      = DEF_COMB_CYCLES,
    parameter int unsigned MOD_START_CYCLES = DEF_MOD_START_CYCLES,
    parameter int unsigned MOD_CYCLES       = DEF_MOD_CYCLES
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic [2:0]       rsp_op,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int unsigned CNT_W =
        $clog2(max3(COMB_CYCLES, MOD_START_CYCLES, MOD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] COMB_LOAD      = CNT_W'(COMB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOD_START_LOAD = CNT_W'(MOD_START_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOD_LOAD       = CNT_W'(MOD_CYCLES - 1);

    issuer_state_e    state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             alu_cin_q, alu_cin_d;
    logic             alu_start_q, alu_start_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

`ifdef ALU_ISSUER_DIVZERO_EN
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] dz_a_q, dz_a_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    alu_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait_counter (
        .clk     (CLK),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_op_d     = rsp_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_cin_d    = alu_cin_q;
        alu_start_d  = alu_start_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef ALU_ISSUER_DIVZERO_EN
        dz_d      = dz_q;
        dz_a_d    = dz_a_q;
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef ALU_ISSUER_DIVZERO_EN
                    // Divide-by-zero request bypasses the ALU; answered after one WAIT cycle.
                    dz_d = (req_op == ALU_MOD) && (req_b == '0);
                    if (dz_d) begin
                        dz_a_d       = req_a;
                        state_d      = ST_WAIT;
                        cnt_load     = 1'b1;
                        cnt_load_val = '0;
                    end else
`endif
                    begin
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_op_d  = req_op;
                        alu_cin_d = req_cin;
                        cnt_load  = 1'b1;
                        if (req_op == ALU_MOD) begin
                            state_d      = ST_START;
                            alu_start_d  = 1'b1;
                            cnt_load_val = MOD_START_LOAD;
                        end else begin
                            state_d      = ST_WAIT;
                            cnt_load_val = COMB_LOAD;
                        end
                    end
                end
            end
            ST_START: begin
                if (cnt_zero) begin
                    alu_start_d  = 1'b0;
                    state_d      = ST_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = MOD_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_cout_d   = alu_cout;
                    rsp_op_d     = alu_op_q;
                    state_d      = ST_RESP;
`ifdef ALU_ISSUER_DIVZERO_EN
                    rsp_err_d = dz_q;
                    if (dz_q) begin
                        rsp_result_d = dz_a_q;
                        rsp_cout_d   = 1'b0;
                        rsp_op_d     = ALU_MOD;
                    end
`endif
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_cin_q    <= 1'b0;
            alu_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_op_q     <= rsp_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_cin_q    <= alu_cin_d;
            alu_start_q  <= alu_start_d;
        end
    end

`ifdef ALU_ISSUER_DIVZERO_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            dz_q      <= 1'b0;
            dz_a_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            dz_q      <= dz_d;
            dz_a_q    <= dz_a_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_op     = rsp_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_cin    = alu_cin_q;
    assign alu_start  = alu_start_q;

endmodule
